// File: rtl/mul_sched_pkg.sv
// ---------------------------------------------------------------------------
// mul_sched_pkg
// Shared types and constants for the taint-tracked multiplier scheduler.
//   sched_state_e : scheduler FSM encoding (IDLE, BUSY, DONE)
//   WIDTH_DEFAULT : default operand width
//   CNT_W         : width of the BUSY-cycle counter (MUL_LATENCY <= 7)
// ---------------------------------------------------------------------------
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam int WIDTH_DEFAULT = 4;
    localparam int CNT_W         = 3;

endpackage

// File: rtl/mul_core_taint.sv
// ---------------------------------------------------------------------------
// mul_core_taint
// Variable-latency multiplier core used by mul_sched_taint. Latches the
// operands on start, counts BUSY cycles, flags completion and registers the
// full-width product together with its sticky result taint.
//
// Optional feature macro: MUL_SCHED_CONST_TIME_EN
//   defined   : no zero-operand early exit, completion always at MUL_LATENCY
//   undefined : completion also when either latched operand is zero
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start_i    in   operation accepted this cycle (latch operands, cnt=1)
//   busy_i     in   scheduler is in BUSY
//   a_i, b_i   in   winner operands
//   opnd_t_i   in   winner operand taint (a_t | b_t)
//   done_o     out  operation completes this BUSY cycle
//   result_o   out  registered product, 2*WIDTH bits
//   res_t_o    out  sticky result taint
// ---------------------------------------------------------------------------
module mul_core_taint
    import mul_sched_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int MUL_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 busy_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 opnd_t_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 res_t_o
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LATENCY);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2*WIDTH-1:0] prod;
    logic               res_t_q, res_t_d;
    logic               lat_hit;

    assign lat_hit = (cnt_q == LAT);
    // Operands are widened before multiplying so the product is never truncated.
    assign prod    = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);

`ifdef MUL_SCHED_CONST_TIME_EN
    assign done_o = busy_i && lat_hit;
`else
    logic zero_opnd;
    assign zero_opnd = (a_q == '0) || (b_q == '0);
    assign done_o    = busy_i && (lat_hit || zero_opnd);
`endif

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        res_t_d  = res_t_q;
        if (start_i) begin
            cnt_d   = CNT_W'(1);
            res_t_d = res_t_q | opnd_t_i;
        end else if (busy_i) begin
            if (done_o) begin
                result_d = prod;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            result_q <= '0;
            res_t_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            res_t_q  <= res_t_d;
        end
    end

    // Operand latches are pure data; they are only meaningful after a start.
    always_ff @(posedge clk) begin
        if (start_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    assign result_o = result_q;
    assign res_t_o  = res_t_q;

endmodule

// File: rtl/mul_sched_taint.sv
// ---------------------------------------------------------------------------
// mul_sched_taint
// Round-robin scheduler sharing one variable-latency multiplier between two
// requesters. Each port carries a 1-bit taint companion; control taint
// (ctl_t) covers response timing, result taint covers the product value.
//
// Optional feature macro: MUL_SCHED_CONST_TIME_EN
//   defined   : constant-time multiply, operand taint kept out of ctl_t
//   undefined : zero-operand early exit, operand taint ORed into ctl_t
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid[1:0]           per-requester valid,   req_valid_t taint
//   req_a, req_b [2*WIDTH]   packed operands (requester 0 in low bits)
//   req_a_t, req_b_t [1:0]   per-requester operand taint
//   req_ready[1:0]           combinational grant,   req_ready_t taint
//   resp_valid/resp_ready    response handshake,    *_t taints
//   resp_id                  requester of the response, resp_id_t taint
//   resp_result [2*WIDTH]    product,                resp_result_t taint
// ---------------------------------------------------------------------------
module mul_sched_taint
    import mul_sched_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int MUL_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_valid_t,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [1:0]           req_a_t,
    input  logic [1:0]           req_b_t,
    output logic [1:0]           req_ready,
    output logic                 req_ready_t,
    output logic                 resp_valid,
    output logic                 resp_valid_t,
    input  logic                 resp_ready,
    input  logic                 resp_ready_t,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_result,
    output logic                 resp_id_t,
    output logic                 resp_result_t
);

    sched_state_e       state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               id_q, id_d;
    logic               ctl_t_q, ctl_t_d;

    logic               any_vld;
    logic               win;
    logic               accept;
    logic [WIDTH-1:0]   win_a, win_b;
    logic               win_opnd_t;
    logic               core_done;
    logic [2*WIDTH-1:0] core_result;
    logic               core_res_t;

    // Arbitration: the pointer's requester wins if valid, else the other one.
    assign any_vld    = |req_valid;
    assign win        = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    assign accept     = (state_q == IDLE) && any_vld;
    assign win_a      = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign win_b      = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign win_opnd_t = req_a_t[win] | req_b_t[win];

    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        ctl_t_d = ctl_t_q;
        unique case (state_q)
            IDLE: begin
                ctl_t_d = ctl_t_q | req_valid_t[0] | req_valid_t[1];
                if (accept) begin
                    id_d    = win;
                    state_d = BUSY;
`ifndef MUL_SCHED_CONST_TIME_EN
                    // Early exit makes timing depend on operand values.
                    ctl_t_d = ctl_t_q | req_valid_t[0] | req_valid_t[1] | win_opnd_t;
`endif
                end
            end
            BUSY: begin
                if (core_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ctl_t_d = ctl_t_q | resp_ready_t;
                if (resp_ready) begin
                    ptr_d   = ~id_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            ctl_t_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            ctl_t_q <= ctl_t_d;
        end
    end

    mul_core_taint #(
        .WIDTH       (WIDTH),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept),
        .busy_i   (state_q == BUSY),
        .a_i      (win_a),
        .b_i      (win_b),
        .opnd_t_i (win_opnd_t),
        .done_o   (core_done),
        .result_o (core_result),
        .res_t_o  (core_res_t)
    );

    assign resp_valid    = (state_q == DONE);
    assign resp_id       = id_q;
    assign resp_result   = core_result;
    assign req_ready_t   = ctl_t_q;
    assign resp_valid_t  = ctl_t_q;
    assign resp_id_t     = ctl_t_q;
    assign resp_result_t = core_res_t | ctl_t_q;

endmodule

// File: tb/tb_mul_sched_taint.sv
module tb_mul_sched_taint;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid, req_valid_t;
    logic [7:0]       req_a, req_b;
    logic [1:0]       req_a_t, req_b_t;
    logic [1:0]       req_ready;
    logic             req_ready_t;
    logic             resp_valid, resp_valid_t;
    logic             resp_ready, resp_ready_t;
    logic             resp_id;
    logic [7:0]       resp_result;
    logic             resp_id_t, resp_result_t;

    int n_tests = 0;
    int n_fail  = 0;
    int guard;

    mul_sched_taint #(.WIDTH(WIDTH), .MUL_LATENCY(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_valid_t   (req_valid_t),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_a_t       (req_a_t),
        .req_b_t       (req_b_t),
        .req_ready     (req_ready),
        .req_ready_t   (req_ready_t),
        .resp_valid    (resp_valid),
        .resp_valid_t  (resp_valid_t),
        .resp_ready    (resp_ready),
        .resp_ready_t  (resp_ready_t),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_id_t     (resp_id_t),
        .resp_result_t (resp_result_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_valid_t = 2'b00;
        req_a = 8'h00; req_b = 8'h00; req_a_t = 2'b00; req_b_t = 2'b00;
        resp_ready = 1'b0; resp_ready_t = 1'b0;

        // Reset state
        nxt(); nxt();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_taints", {req_ready_t, resp_valid_t, resp_id_t, resp_result_t}, 0);
        rst = 1'b0;

        // Req0 3*5, k = MUL_LATENCY = 2
        nxt();
        req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05; #1;
        chk("t1_ready", req_ready, 2'b01);
        nxt(); req_valid = 2'b00; #1;
        chk("t1_busy1", resp_valid, 0);
        nxt();
        chk("t1_busy2", resp_valid, 0);
        nxt();
        chk("t1_valid", resp_valid, 1);
        chk("t1_result", resp_result, 15);
        chk("t1_id", resp_id, 0);
        chk("t1_taints", {req_ready_t, resp_valid_t, resp_id_t, resp_result_t}, 0);
        resp_ready = 1'b1;
        nxt();
        chk("t1_idle", resp_valid, 0);

        // Req1 0*9 with a taint
        nxt();
        req_valid = 2'b10; req_a = 8'h00; req_b = 8'h90; req_a_t = 2'b10; #1;
        chk("t2_ready", req_ready, 2'b10);
        nxt(); req_valid = 2'b00; req_a_t = 2'b00; #1;
        chk("t2_busy1", resp_valid, 0);
`ifdef MUL_SCHED_CONST_TIME_EN
        chk("t2_vt_busy", resp_valid_t, 0);
        nxt();
        chk("t2_busy2", resp_valid, 0);
        nxt();
        chk("t2_valid", resp_valid, 1);
        chk("t2_result", resp_result, 0);
        chk("t2_id", resp_id, 1);
        chk("t2_valid_t", resp_valid_t, 0);
        chk("t2_result_t", resp_result_t, 1);
`else
        chk("t2_vt_busy", resp_valid_t, 1);
        nxt();
        chk("t2_valid", resp_valid, 1);
        chk("t2_result", resp_result, 0);
        chk("t2_id", resp_id, 1);
        chk("t2_valid_t", resp_valid_t, 1);
        chk("t2_result_t", resp_result_t, 1);
`endif
        nxt();
        chk("t2_idle", resp_valid, 0);

        // Reset clears sticky taint
        rst = 1'b1;
        nxt(); nxt();
        chk("t2_rst_taints", {req_ready_t, resp_valid_t, resp_id_t, resp_result_t}, 0);
        rst = 1'b0;

        // Alternating grants with both requesters valid and resp_ready high
        nxt();
        req_valid = 2'b11; req_a = 8'h42; req_b = 8'h53; resp_ready = 1'b1; #1;
        for (int g = 0; g < 4; g++) begin
            guard = 0;
            while (req_ready == 2'b00 && guard < 10) begin nxt(); guard++; end
            chk("alt_grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            guard = 0;
            while (!resp_valid && guard < 10) begin nxt(); guard++; end
            chk("alt_timeout", guard < 10, 1);
            chk("alt_id", resp_id, g % 2);
            chk("alt_result", resp_result, (g % 2 == 0) ? 6 : 20);
            nxt();
        end
        req_valid = 2'b00; #1;

        // Back-pressure: 15*15 held in DONE for 4 cycles
        nxt();
        resp_ready = 1'b0;
        req_valid = 2'b01; req_a = 8'h0F; req_b = 8'h0F; #1;
        chk("t4_ready", req_ready, 2'b01);
        nxt(); req_valid = 2'b11; #1;
        chk("t4_busy_ready", req_ready, 2'b00);
        nxt();
        chk("t4_busy2", resp_valid, 0);
        nxt();
        chk("t4_valid", resp_valid, 1);
        chk("t4_result", resp_result, 8'hE1);
        chk("t4_id", resp_id, 0);
        chk("t4_done_ready", req_ready, 2'b00);
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("t4_hold_valid", resp_valid, 1);
            chk("t4_hold_result", resp_result, 8'hE1);
            chk("t4_hold_id", resp_id, 0);
            chk("t4_hold_ready", req_ready, 2'b00);
        end
        resp_ready = 1'b1;
        nxt();
        chk("t4_idle_valid", resp_valid, 0);
        chk("t4_idle_grant", req_ready, 2'b10);
        req_valid = 2'b00; #1;

        // Reset during the second BUSY cycle (ptr is 1 beforehand)
        nxt();
        req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05; req_a_t = 2'b01; #1;
        chk("t5_ready", req_ready, 2'b01);
        nxt(); req_valid = 2'b00; req_a_t = 2'b00; #1;
        chk("t5_busy_rt", resp_result_t, 1);
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0; #1;
        chk("t5_no_resp", resp_valid, 0);
        chk("t5_result", resp_result, 0);
        chk("t5_id", resp_id, 0);
        chk("t5_taints", {req_ready_t, resp_valid_t, resp_id_t, resp_result_t}, 0);
        chk("t5_idle_ready", req_ready, 2'b00);
        req_valid = 2'b11; #1;
        chk("t5_ptr_zero", req_ready, 2'b01);
        req_valid = 2'b00; #1;
        nxt();
        chk("t5_still_idle", resp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_sched_taint.md
# mul_sched_taint

Taint-tracked scheduler that shares one variable-latency multiplier between two requesters. It arbitrates round-robin, sequences each operation through the multiplier core, and returns the product with the requester ID over a valid/ready handshake. Every data and control port carries a 1-bit taint companion, so information flow from operands into response timing can be checked formally. It sits between the request sources and the result buffering stage.

## Interface
- WIDTH, 4: operand width; products are 2*WIDTH bits.
- MUL_LATENCY, 2: BUSY cycles for a non-zero-operand multiply; must be ≥1 and ≤7.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  2  per-requester request valid.
- req_valid_t  input  2  taint of req_valid, one bit per requester.
- req_a, req_b  input  2×WIDTH  per-requester operands (packed, index 0 in the low bits).
- req_a_t, req_b_t  input  2  per-requester operand taint.
- req_ready  output  2  request accepted this cycle (combinational).
- req_ready_t  output  1  taint of req_ready.
- resp_valid  output  1  response available.
- resp_valid_t  output  1  taint of resp_valid.
- resp_ready  input  1  consumer accepts the response.
- resp_ready_t  input  1  taint of resp_ready.
- resp_id  output  1  requester index of the response.
- resp_result  output  2*WIDTH  product.
- resp_id_t, resp_result_t  output  1  taints of resp_id and resp_result.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: state IDLE, rr pointer 0, cnt 0, resp_id 0, resp_result 0, every taint register 0.
- IDLE: winner is req_valid[ptr] if set, otherwise the other valid requester. req_ready[winner]=1 and the other bit is 0; both bits are 0 when no request is valid.
- Acceptance: latch operands and winner ID, set cnt=1, go to BUSY.
- BUSY: done when cnt==MUL_LATENCY or either latched operand is 0. When done, load resp_result = a*b at full 2*WIDTH width (no truncation) and go to DONE. Otherwise increment cnt.
- DONE: resp_valid=1. resp_id and resp_result stay stable until resp_valid && resp_ready. On that handshake: ptr = !resp_id, go to IDLE.
- No new request is accepted in BUSY or DONE. A request held high while waiting is served in the next IDLE cycle.
- Reset in any state aborts the in-flight operation with no response, and all registers return to their reset values.
- Taint, all sticky until rst:
  - ctl_t |= req_valid_t[0]|req_valid_t[1] on every IDLE cycle.
  - ctl_t |= resp_ready_t in DONE.
  - ctl_t |= winner's a_t|b_t at acceptance.
  - res_t |= winner's a_t|b_t at acceptance.
  - req_ready_t = resp_valid_t = resp_id_t = ctl_t. resp_result_t = res_t|ctl_t.

## Timing
- Acceptance is at the edge ending cycle T (req_valid && req_ready). resp_valid first rises in cycle T+1+k:
  - k = MUL_LATENCY with non-zero operands.
  - k = 1 when either operand is 0.
- One operation in flight at a time. Back-to-back throughput is one operation per (k+1+resp wait+1) cycles.
- resp_ready held high: the handshake completes in the first DONE cycle, and IDLE follows in the next cycle.
- req_ready depends combinationally on req_valid and state only, never on resp_ready.

## Configuration
- MUL_SCHED_CONST_TIME_EN defined:
  - The zero-operand early exit is removed, so k = MUL_LATENCY always.
  - Operand taint is not ORed into ctl_t; it still feeds res_t.
  - Result: response timing is provably independent of operand values.
- Not defined: the early-exit behaviour and the ctl_t operand term described above apply.

## Structure
- Package mul_sched_pkg holds:
  - state enum sched_state_e {IDLE, BUSY, DONE};
  - WIDTH_DEFAULT;
  - the cnt width constant (3 bits).
- Sub-module mul_core_taint holds cnt, the early-exit compare, the product register and res_t. The scheduler keeps the FSM, the rr pointer and ctl_t.

## Test plan
- Req0 a=3 b=5, no taint, accept at T → resp_valid at T+3 (MUL_LATENCY=2), result 15, id 0, all taints 0.
- Req1 a=0 b=9 with req_a_t=1 → resp_valid at T+2, result 0, resp_valid_t=1. With MUL_SCHED_CONST_TIME_EN: response at T+3, resp_valid_t=0, resp_result_t=1.
- Both requesters valid continuously, resp_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset.
- resp_ready held low for 4 DONE cycles → resp_valid, id and result stable; req_ready=00 throughout; IDLE in the cycle after resp_ready rises.
- rst asserted in the second BUSY cycle → no response; next cycle in IDLE; ptr=0; all outputs and taints 0.
- a=15 b=15 → result 225 (8'hE1), no overflow.
